data_ram_arbiter: RTL

Two-requester arbiter and sequencer for the single-port data RAM (32-bit words, 328 entries, registered read with one-cycle latency, write when `wren`=1). It shares the RAM between requester A (processor load/store path) and requester B (text/frame reader scanning the stored phrase). It serialises their accesses with round-robin priority, rejects out-of-range addresses, and returns read data with a valid pulse.

---
 rtl/data_ram_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_arbiter
// Description : Round-robin arbiter/sequencer sharing one single-port data
//               RAM (registered read, 1-cycle latency) between requester A
//               (load/store path) and requester B (frame/text reader).
//               Out-of-range addresses are rejected with an error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_arbiter #(
    parameter int DEPTH  = 328,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    // requester A
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    // requester B
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    // RAM side
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

    // requester encoding for r_last / r_owner: 0 = A, 1 = B
    logic [1:0]        r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_rej;
    logic              r_rd;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_any;
    logic              w_win;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_ok;
    logic              w_issue;
    logic              w_resp;

    // Pick the winner: on a tie, the requester that was not served last.
    always_comb begin
        w_any   = a_req | b_req;
        w_win   = (a_req & b_req) ? ~r_last : b_req;
        w_we    = w_win ? b_we    : a_we;
        w_addr  = w_win ? b_addr  : a_addr;
        w_wdata = w_win ? b_wdata : a_wdata;
        w_ok    = (w_addr < c_DEPTH);
    end

    // Sequencer: IDLE registers the command, ISSUE presents it, RESP returns data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_last        <= 1'b1;
            r_owner       <= 1'b0;
            r_rej         <= 1'b0;
            r_rd          <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_owner       <= w_win;
                        r_last        <= w_win;
                        r_ram_address <= w_addr;
                        r_ram_data    <= w_wdata;
                        // a rejected write must never reach the RAM
                        r_ram_wren    <= w_we & w_ok;
                        r_rej         <= ~w_ok;
                        r_rd          <= ~w_we;
                        r_state       <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_ram_wren <= 1'b0;
                    r_state    <= (r_rd & ~r_rej) ? c_RESP : c_IDLE;
                end
                c_RESP: begin
                    // keep a copy so rdata holds its value after the pulse
                    if (r_owner) begin
                        r_b_rdata <= ram_q;
                    end else begin
                        r_a_rdata <= ram_q;
                    end
                    r_state <= c_IDLE;
                end
                default: begin
                    r_ram_wren <= 1'b0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

    // Grant/error/valid pulses are decoded from the state and current owner.
    always_comb begin
        w_issue  = (r_state == c_ISSUE);
        w_resp   = (r_state == c_RESP);
        a_gnt    = w_issue & ~r_owner;
        b_gnt    = w_issue &  r_owner;
        a_err    = a_gnt & r_rej;
        b_err    = b_gnt & r_rej;
        a_rvalid = w_resp & ~r_owner;
        b_rvalid = w_resp &  r_owner;
        a_rdata  = a_rvalid ? ram_q : r_a_rdata;
        b_rdata  = b_rvalid ? ram_q : r_b_rdata;
    end

    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign ram_wren    = r_ram_wren;

endmodule
`default_nettype wire
